// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and next-PC select codes for the pipeline hazard controller.
package hazard_pkg;
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_STALL2  = 2'd1;
    localparam logic [1:0] ST_HALT    = 2'd2;
    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_JMP = 2'b10;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: stall depth needed by the instruction in ID (0, 1 or 2 cycles).
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_branch,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_mem_read,
    output logic [1:0]            need
);
    logic ex_match;
    logic mem_match;
    always_comb begin
        ex_match  = (ex_rd != '0) && (ex_rd == id_rs || ex_rd == id_rt);
        mem_match = (mem_rd != '0) && (mem_rd == id_rs || mem_rd == id_rt);
        // A branch compares in ID, so it must wait for ALU results too, and for loads until WB-forwardable.
        need = (id_branch && ex_mem_read && ex_match) ? 2'd2 :
               ((id_branch && ((ex_reg_write && !ex_mem_read && ex_match) || (mem_mem_read && mem_match))) ||
                (!id_branch && ex_mem_read && ex_match)) ? 2'd1 : 2'd0;
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: PC/IF-ID/ID-EX sequencing with load-use and branch-operand stalls.
// Define HAZARD_PERF_CNT_EN to add stall_cycles/flush_count performance counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ext_stall,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_branch,
    input  logic                  id_jump,
    input  logic                  id_halt,
    input  logic                  branch_eq,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_mem_read,
    output logic                  pc_ld,
    output logic [1:0]            pc_sel,
    output logic                  ifid_ld,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  pipe_freeze,
    output logic                  halted
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count
`endif
);
    logic [1:0] state_q, state_d;
    logic [1:0] need;
    logic       stall_cyc;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_detect (
        .id_rs(id_rs), .id_rt(id_rt), .id_branch(id_branch),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_mem_read(mem_mem_read), .need(need)
    );

    always_comb begin
        state_d     = state_q;
        pc_ld       = 1'b0;
        pc_sel      = PC_SEL_SEQ;
        ifid_ld     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b1;
        pipe_freeze = 1'b0;
        halted      = rst && state_q == ST_HALT;
        stall_cyc   = 1'b0;
        if (!rst) begin
            state_d = ST_RUN;
        end else if (ext_stall) begin
            idex_bubble = 1'b0;
            pipe_freeze = 1'b1;
        end else if (state_q == ST_HALT) begin
            state_d = ST_HALT;
        end else if (state_q == ST_STALL2 || need != 2'd0) begin
            stall_cyc = 1'b1;
            state_d   = (state_q == ST_RUN && need == 2'd2) ? ST_STALL2 : ST_RUN;
        end else if (id_halt) begin
            state_d = ST_HALT;
        end else begin
            pc_ld       = 1'b1;
            ifid_ld     = 1'b1;
            idex_bubble = 1'b0;
            ifid_flush  = (id_branch && branch_eq) || id_jump;
            pc_sel      = (id_branch && branch_eq) ? PC_SEL_BR : id_jump ? PC_SEL_JMP : PC_SEL_SEQ;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_RUN;
        else      state_q <= state_d;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;
    always_comb begin
        stall_cycles_d = stall_cycles_q + (stall_cyc ? 32'd1 : 32'd0);
        flush_count_d  = flush_count_q + (ifid_flush ? 32'd1 : 32'd0);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif
endmodule
